// File: rtl/uart_rx_deser_if.sv
// uart_rx_deser_if -- word-delivery handshake between the UART receiver and its consumer.
//   rx_ready_i  : consumer accepts the held word when high together with rx_valid_o
//   rx_data_o   : received word (first bit on the line lands in bit 0)
//   rx_valid_o  : rx_data_o and the flags are valid and held until accepted
//   rx_ferr_o   : framing error flag for the held word
//   rx_perr_o   : parity error flag for the held word (UART_RX_PARITY_EN builds only)
//   overrun_o   : one-cycle pulse when a completed word was dropped
// master = receiver, slave = consumer.
interface uart_rx_deser_if #(parameter int DATA_BITS = 8);
  logic                 rx_ready_i;
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic                 rx_ferr_o;
`ifdef UART_RX_PARITY_EN
  logic                 rx_perr_o;
`endif
  logic                 overrun_o;

  modport master (
    input  rx_ready_i,
    output rx_data_o, rx_valid_o, rx_ferr_o, overrun_o
`ifdef UART_RX_PARITY_EN
    , output rx_perr_o
`endif
  );

  modport slave (
    output rx_ready_i,
    input  rx_data_o, rx_valid_o, rx_ferr_o, overrun_o
`ifdef UART_RX_PARITY_EN
    , input rx_perr_o
`endif
  );
endinterface

// File: rtl/uart_rx_deser.sv
// uart_rx_deser -- 16x oversampling UART receive deserializer.
// Detects a start bit, re-checks it mid-bit, samples each following bit at its
// centre (every 16th enable tick), then presents the word on a valid/ready
// handshake that holds the word until accepted.
// Ports:
//   clk_i      : system clock, all state on rising edge
//   rst_i      : asynchronous active-low reset
//   enable_i   : 16x-baud tick, one clk_i cycle wide
//   srx_i      : serial line, already synchronized, idle high
//   even_par_i : 1 = even parity, 0 = odd (UART_RX_PARITY_EN builds only)
//   rx         : uart_rx_deser_if.master word-delivery port
// Build option: define UART_RX_PARITY_EN to add the parity bit to the frame,
// the even_par_i input and the rx_perr_o flag.
module uart_rx_deser #(
  parameter int DATA_BITS = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              srx_i,
`ifdef UART_RX_PARITY_EN
  input  logic              even_par_i,
`endif
  uart_rx_deser_if.master   rx
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ferr_q, ovr_q;
`ifdef UART_RX_PARITY_EN
  logic                 perr_smp_q, perr_q;
  logic                 par_smp;
`endif
  logic                 cnt_clr, cnt_inc, idx_clr, bit_smp, done;

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (enable_i) begin
      case (state_q)
        S_IDLE:   if (!srx_i) state_d = S_START;
        // Mid-start re-check: a line back high here was a glitch.
        S_START:  if (cnt_q == 4'd7) state_d = srx_i ? S_IDLE : S_DATA;
        S_DATA:   if (cnt_q == 4'd15 && idx_q == LAST)
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
        S_PARITY: if (cnt_q == 4'd15) state_d = S_STOP;
`else
                    state_d = S_STOP;
`endif
        S_STOP:   if (cnt_q == 4'd15) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    idx_clr = 1'b0;
    bit_smp = 1'b0;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp = 1'b0;
`endif
    if (enable_i) begin
      case (state_q)
        S_IDLE:   cnt_clr = !srx_i;
        S_START:  if (cnt_q == 4'd7) begin
                    cnt_clr = 1'b1;
                    idx_clr = 1'b1;
                  end else begin
                    cnt_inc = 1'b1;
                  end
        // cnt wraps 15 -> 0 naturally, so the next bit starts counting at once.
        S_DATA:   begin cnt_inc = 1'b1; bit_smp = (cnt_q == 4'd15); end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin cnt_inc = 1'b1; par_smp = (cnt_q == 4'd15); end
`endif
        S_STOP:   begin cnt_inc = 1'b1; done = (cnt_q == 4'd15); end
        default:  cnt_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_smp_q <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 4'd1;

      if (idx_clr)      idx_q <= '0;
      else if (bit_smp) idx_q <= idx_q + IW'(1);

      if (bit_smp) shreg_q[idx_q] <= srx_i;
`ifdef UART_RX_PARITY_EN
      // ones(data)+parity must be even (even_par_i=1) or odd (even_par_i=0).
      if (par_smp) perr_smp_q <= (^shreg_q) ^ srx_i ^ ~even_par_i;
`endif

      ovr_q <= 1'b0;
      if (done) begin
        // Slot is free if empty or being accepted this very cycle.
        if (!valid_q || rx.rx_ready_i) begin
          data_q  <= shreg_q;
          ferr_q  <= ~srx_i;
          valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_q  <= perr_smp_q;
`endif
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx.rx_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data_o  = data_q;
  assign rx.rx_valid_o = valid_q;
  assign rx.rx_ferr_o  = ferr_q;
  assign rx.overrun_o  = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rx.rx_perr_o  = perr_q;
`endif

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 SHALL have parameter: DATA_BITS, 8, number of data bits per frame (5..8).
REQ-002 SHALL have port: clk_i  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: enable_i  input  1  16x-baud tick, one clk_i cycle wide.
REQ-005 SHALL have port: srx_i  input  1  serial line, already two-flop synchronized upstream, idle high.
REQ-006 SHALL have port: rx_ready_i  input  1  consumer accepts rx_data_o when high with rx_valid_o.
REQ-007 SHALL have port: rx_data_o  output  DATA_BITS  received word, LSB first on line.
REQ-008 SHALL have port: rx_valid_o  output  1  rx_data_o and flags valid.
REQ-009 SHALL have port: rx_ferr_o  output  1  framing error flag for held word.
REQ-010 SHALL have port: overrun_o  output  1  one-cycle pulse, completed word dropped.
REQ-011 SHALL have port (UART_RX_PARITY_EN only): even_par_i  input  1  1=even, 0=odd; rx_perr_o  output  1  parity error flag for held word.

Function
REQ-012 SHALL implement FSM IDLE, START, DATA, PARITY, STOP; 4-bit tick counter cnt; bit index idx.
REQ-013 SHALL advance cnt and sample srx_i only in cycles with enable_i=1; all other cycles hold state.
REQ-014 IDLE: on enable_i with srx_i=0 SHALL go START, cnt=0.
REQ-015 START: at enable_i with cnt=7 SHALL sample; srx_i=0 -> DATA, cnt=0, idx=0; srx_i=1 -> IDLE (glitch reject, no output).
REQ-016 DATA: at enable_i with cnt=15 SHALL shift srx_i in at bit idx (LSB first), cnt wraps to 0; after idx=DATA_BITS-1 -> PARITY if enabled else STOP.
REQ-017 PARITY: at cnt=15 SHALL sample parity bit; perr = (XOR data XOR bit) != (even_par_i ? 0 : 1) ... i.e. even: total ones incl. bit even; odd: odd; -> STOP.
REQ-018 STOP: at cnt=15 SHALL sample; ferr = ~srx_i; complete word; -> IDLE same edge (next start detectable on next tick).
REQ-019 Word completion SHALL set rx_valid_o=1 and load rx_data_o, rx_ferr_o, rx_perr_o on the clock edge of the stop sample (latency 0 clk after stop-sample tick edge).
REQ-020 rx_valid_o SHALL stay high and outputs stable until cycle with rx_valid_o=1 and rx_ready_i=1; then clear next edge.
REQ-021 Completion while rx_valid_o=1 and rx_ready_i=0: held word unchanged, new word dropped, overrun_o=1 for exactly that cycle.
REQ-022 Completion in same cycle as accept (rx_valid_o=1, rx_ready_i=1): new word loaded, rx_valid_o stays 1, no overrun.
REQ-023 Framing-error word SHALL still be delivered with rx_ferr_o=1; receiver returns to IDLE regardless of stop value.
REQ-024 srx_i changes between sample points SHALL have no effect.

Reset
REQ-025 rst_i=0 SHALL asynchronously force: state IDLE, cnt=0, idx=0, rx_data_o=0, rx_valid_o=0, rx_ferr_o=0, rx_perr_o=0, overrun_o=0.
REQ-026 Reset mid-frame SHALL discard partial word; after release receiver waits in IDLE for a new falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state, even_par_i, rx_perr_o present; frame = start+DATA_BITS+parity+stop.
REQ-028 UART_RX_PARITY_EN undefined: no PARITY state, no even_par_i/rx_perr_o ports; DATA goes directly to STOP.

Verification
REQ-029 Frame 0x55, stop=1, 16 ticks/bit, rx_ready_i=1 -> one rx_valid_o pulse, rx_data_o=0x55, rx_ferr_o=0.
REQ-030 srx_i low for 4 ticks then high -> FSM back to IDLE after start check, no rx_valid_o.
REQ-031 Frame 0xA3 with stop=0 -> rx_data_o=0xA3, rx_ferr_o=1, next frame 0x12 received clean.
REQ-032 rx_ready_i=0, frames 0x01 then 0x02 -> rx_data_o=0x01 held, overrun_o one-cycle pulse at second stop sample.
REQ-033 UART_RX_PARITY_EN, even_par_i=1, 0x07 with parity bit 0 -> rx_perr_o=1; parity bit 1 -> rx_perr_o=0.
REQ-034 rst_i low during DATA bit 4 of 0xFF -> all outputs 0 immediately; after release, frame 0x3C received correctly.
